v_alu_seq: RTL and testbench
============================

# v_alu_seq

Vector ALU sequencer for the Carrd coprocessor. It accepts one vector instruction with full-width operands, slices them into 32-bit words and issues one word per cycle to `v_alu`. It accounts for the one-cycle registered latency of the add/sub path, reassembles the result vector and returns it through a valid/ready handshake. It sits between the vector issue stage and the single `v_alu` instance.

## Interface
- `VECTOR_LENGTH`, default 128: vector register width in bits. Must be a multiple of 32.
- `VALU_OP_W_MAX`, default 32: ALU word width. Fixed at 32.
- `NWORDS`, default `VECTOR_LENGTH/32`: local, not overridable.
- `clk` in 1: clock.
- `nrst` in 1: asynchronous active-low reset.
- `instr_valid` in 1: instruction offered.
- `instr_ready` out 1: sequencer can accept; equals `nrst && state==IDLE`.
- `instr_op` in 4: v_pkg VALU opcode.
- `instr_vsew` in 2: v_pkg VSEW encoding.
- `instr_nwords` in `$clog2(NWORDS)+1`: number of active 32-bit words. Values above `NWORDS` are clamped to `NWORDS`.
- `instr_vA`, `instr_vB` in `VECTOR_LENGTH`: source vectors.
- `alu_op_instr` out 4, `alu_vsew` out 2, `alu_op_A` out 32, `alu_op_B` out 32: drive `v_alu`.
- `alu_result` in 32: from `v_alu`.
- `res_valid` out 1, `res_ready` in 1: result handshake.
- `res_vd` out `VECTOR_LENGTH`: assembled result.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- **IDLE.** Handshake `instr_valid && instr_ready`:
  - Latch op, vsew, clamped nwords, vA and vB.
  - Clear `res_vd` to 0.
  - `lat` = 1 if op is VALU_VADD or VALU_VSUB, else 0.
  - If nwords == 0, go to DONE; otherwise go to ISSUE with `issue_idx` = 0.
- **ISSUE.** Each cycle:
  - Drive `alu_op_A = vA[32*issue_idx +: 32]` and `alu_op_B = vB[32*issue_idx +: 32]`.
  - If `lat`==0, capture `alu_result` into word `issue_idx` of `res_vd` in the same cycle.
  - If `lat`==1, capture into word `issue_idx-1` when `issue_idx` > 0.
  - After word nwords-1: go to DRAIN if `lat`, else to DONE.
- **DRAIN.** Operands driven as 0. Capture `alu_result` into word nwords-1. Go to DONE.
- **DONE.** `res_valid`=1 and `res_vd` held stable. On `res_ready`, go to IDLE.
- `alu_op_instr` and `alu_vsew` hold the latched instruction from acceptance until the next acceptance. Holding them is mandatory, because the v_alu output mux decodes `op_instr` combinationally while the add/sub result is still in flight.
- In IDLE and DONE, `alu_op_A` and `alu_op_B` are 0.
- Words at index ≥ nwords read 0 in `res_vd`.
- The sequencer never interprets element widths. Per-element arithmetic is entirely v_alu's.

## Timing
- Reset values:
  - state IDLE.
  - `res_valid` 0, `res_vd` 0.
  - `alu_op_instr` 4'd0, `alu_vsew` 2'd0, `alu_op_A` 0, `alu_op_B` 0.
  - `instr_ready` 0 while `nrst` is low.
- Accept in cycle T. Word i is issued in cycle T+1+i.
- `res_valid` rises at T+1+n when `lat`=0 and at T+2+n when `lat`=1.
- nwords == 0: `res_valid` rises at T+1 with `res_vd` = 0.
- The result handshake completes in cycle R. State is IDLE and `instr_ready`=1 at R+1. There is no same-cycle overlap of result and new instruction.
- `res_valid` stays high, with `res_vd` unchanged, for any number of cycles with `res_ready` low.
- `nrst` asserted in any state forces all reset values immediately. The in-flight instruction is discarded and no partial result is presented.

## Configuration
- `V_ALU_SEQ_PERF_EN` defined:
  - Adds output `perf_busy_cycles` [31:0].
  - Increments every cycle that state != IDLE and saturates at 32'hFFFFFFFF.
  - Reset value 0.
- `V_ALU_SEQ_PERF_EN` undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- VADD, VSEW_8, nwords=1, word0 vA=32'h7F01FF10, vB=32'h01010110 -> `res_vd[31:0]`=32'h80020020, `res_valid` at T+3.
- VAND, nwords=4, vA=all 32'hF0F0F0F0, vB=all 32'h3C3C3C3C -> `res_vd` = four words of 32'h30303030, `res_valid` at T+5, each word captured in its own issue cycle.
- VADD, VSEW_32, nwords=2, word0 1+2, word1 32'hFFFFFFFF+1 -> word0=3, word1=0, words 2–3 = 0, `res_valid` at T+4.
- VOR, nwords=0 -> `res_valid` at T+1, `res_vd`=0. With `res_ready` low for 3 cycles: `res_vd` stable, `instr_ready`=0, IDLE only after the handshake.
- `nrst` pulsed low during ISSUE word 1 -> `res_valid`=0 and `alu_op_A`=0 immediately. After release, `instr_ready`=1 and a fresh VADD completes correctly.
- With `V_ALU_SEQ_PERF_EN`: VADD nwords=4 plus 2 backpressure cycles -> `perf_busy_cycles`=8.

Source files
------------

// File: rtl/v_alu_seq.sv
// v_alu_seq: slices one vector instruction into 32-bit words, issues them to v_alu one per cycle
// and reassembles the result vector. Optional macro V_ALU_SEQ_PERF_EN adds perf_busy_cycles.
module v_alu_seq #(
    parameter int VECTOR_LENGTH = 128,
    parameter int VALU_OP_W_MAX = 32,
    localparam int NWORDS = VECTOR_LENGTH / 32,
    localparam int NW_W = $clog2(NWORDS) + 1
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic [3:0]               instr_op,
    input  logic [1:0]               instr_vsew,
    input  logic [NW_W-1:0]          instr_nwords,
    input  logic [VECTOR_LENGTH-1:0] instr_vA,
    input  logic [VECTOR_LENGTH-1:0] instr_vB,
    output logic [3:0]               alu_op_instr,
    output logic [1:0]               alu_vsew,
    output logic [VALU_OP_W_MAX-1:0] alu_op_A,
    output logic [VALU_OP_W_MAX-1:0] alu_op_B,
    input  logic [VALU_OP_W_MAX-1:0] alu_result,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [VECTOR_LENGTH-1:0] res_vd
`ifdef V_ALU_SEQ_PERF_EN
    ,
    output logic [31:0]              perf_busy_cycles
`endif
);

    localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [3:0] VALU_VADD = 4'd1;
    localparam logic [3:0] VALU_VSUB = 4'd2;

    // Both handshakes: a transfer happens on a rising clk edge where valid && ready are both high.
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                               state;
    logic [NW_W-1:0]                      nwords_q;
    logic [NWORDS-1:0][VALU_OP_W_MAX-1:0] va_q;
    logic [NWORDS-1:0][VALU_OP_W_MAX-1:0] vb_q;
    logic [NWORDS-1:0][VALU_OP_W_MAX-1:0] res_q;
    logic                                 lat_q;
    logic [IDX_W-1:0]                     issue_idx;
    logic [NW_W-1:0]                      nwords_clamp;
    logic                                 last_word;
    logic [IDX_W-1:0]                     drain_idx;

    assign nwords_clamp = (instr_nwords > NW_W'(NWORDS)) ? NW_W'(NWORDS) : instr_nwords;
    assign last_word    = (NW_W'(issue_idx) == nwords_q - NW_W'(1));
    assign drain_idx    = IDX_W'(nwords_q - NW_W'(1));

    assign instr_ready = nrst && (state == IDLE);
    assign res_valid   = (state == DONE);
    assign res_vd      = res_q;
    assign alu_op_A    = (state == ISSUE) ? va_q[issue_idx] : '0;
    assign alu_op_B    = (state == ISSUE) ? vb_q[issue_idx] : '0;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state        <= IDLE;
            alu_op_instr <= 4'd0;
            alu_vsew     <= 2'd0;
            nwords_q     <= '0;
            va_q         <= '0;
            vb_q         <= '0;
            res_q        <= '0;
            lat_q        <= 1'b0;
            issue_idx    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        alu_op_instr <= instr_op;
                        alu_vsew     <= instr_vsew;
                        nwords_q     <= nwords_clamp;
                        va_q         <= instr_vA;
                        vb_q         <= instr_vB;
                        res_q        <= '0;
                        lat_q        <= (instr_op == VALU_VADD) || (instr_op == VALU_VSUB);
                        issue_idx    <= '0;
                        state        <= (nwords_clamp == '0) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    // Add/sub results emerge one cycle late, so they land one word behind the issue index.
                    if (!lat_q) begin
                        res_q[issue_idx] <= alu_result;
                    end else if (issue_idx != '0) begin
                        res_q[issue_idx - IDX_W'(1)] <= alu_result;
                    end
                    if (last_word) begin
                        state <= lat_q ? DRAIN : DONE;
                    end else begin
                        issue_idx <= issue_idx + IDX_W'(1);
                    end
                end
                DRAIN: begin
                    res_q[drain_idx] <= alu_result;
                    state            <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef V_ALU_SEQ_PERF_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            perf_busy_cycles <= 32'd0;
        end else if ((state != IDLE) && (perf_busy_cycles != 32'hFFFF_FFFF)) begin
            perf_busy_cycles <= perf_busy_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_v_alu_seq.sv
// Bench for v_alu_seq: a behavioural v_alu (registered add/sub, combinational logic ops) plus
// a vector-level reference model, directed cases and randomized instructions.
`timescale 1ns/1ps
module tb_v_alu_seq;

    localparam int VL     = 128;
    localparam int NWORDS = VL / 32;
    localparam int NW_W   = $clog2(NWORDS) + 1;

    localparam logic [3:0] VALU_VADD = 4'd1;
    localparam logic [3:0] VALU_VSUB = 4'd2;
    localparam logic [3:0] VALU_VAND = 4'd3;
    localparam logic [3:0] VALU_VOR  = 4'd4;
    localparam logic [3:0] VALU_VXOR = 4'd5;

    logic            clk;
    logic            nrst;
    logic            instr_valid;
    logic            instr_ready;
    logic [3:0]      instr_op;
    logic [1:0]      instr_vsew;
    logic [NW_W-1:0] instr_nwords;
    logic [VL-1:0]   instr_vA;
    logic [VL-1:0]   instr_vB;
    logic [3:0]      alu_op_instr;
    logic [1:0]      alu_vsew;
    logic [31:0]     alu_op_A;
    logic [31:0]     alu_op_B;
    logic [31:0]     alu_result;
    logic            res_valid;
    logic            res_ready;
    logic [VL-1:0]   res_vd;
`ifdef V_ALU_SEQ_PERF_EN
    logic [31:0]     perf_busy_cycles;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [VL-1:0] exp_q[$];

    v_alu_seq #(.VECTOR_LENGTH(VL)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_op     (instr_op),
        .instr_vsew   (instr_vsew),
        .instr_nwords (instr_nwords),
        .instr_vA     (instr_vA),
        .instr_vB     (instr_vB),
        .alu_op_instr (alu_op_instr),
        .alu_vsew     (alu_vsew),
        .alu_op_A     (alu_op_A),
        .alu_op_B     (alu_op_B),
        .alu_result   (alu_result),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_vd       (res_vd)
`ifdef V_ALU_SEQ_PERF_EN
        ,
        .perf_busy_cycles (perf_busy_cycles)
`endif
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout sim_time=%0t required=finish", $time);
        $fatal(1, "timeout");
    end

    // ---------------- reference arithmetic ----------------
    function automatic bit is_arith(input logic [3:0] op);
        return (op == VALU_VADD) || (op == VALU_VSUB);
    endfunction

    function automatic logic [31:0] ref_word(input logic [3:0] op, input logic [1:0] vsew,
                                             input logic [31:0] a, input logic [31:0] b);
        int ew;
        longint unsigned mask, la, lb, lr;
        logic [31:0] r;
        ew   = (vsew == 2'd0) ? 8 : (vsew == 2'd1) ? 16 : 32;
        mask = (64'd1 << ew) - 64'd1;
        r    = '0;
        case (op)
            VALU_VAND: r = a & b;
            VALU_VOR:  r = a | b;
            VALU_VXOR: r = a ^ b;
            VALU_VADD, VALU_VSUB: begin
                for (int l = 0; l < 32 / ew; l++) begin
                    la = (64'(a) >> (l * ew)) & mask;
                    lb = (64'(b) >> (l * ew)) & mask;
                    lr = (op == VALU_VADD) ? la + lb : la - lb;
                    r  = r | 32'((lr & mask) << (l * ew));
                end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Behavioural v_alu: add/sub registered one cycle, logic ops combinational.
    logic [31:0] add_q;
    always @(posedge clk) add_q <= ref_word(alu_op_instr, alu_vsew, alu_op_A, alu_op_B);
    always_comb begin
        alu_result = ref_word(alu_op_instr, alu_vsew, alu_op_A, alu_op_B);
        if (is_arith(alu_op_instr)) alu_result = add_q;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [VL-1:0] got, input logic [VL-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Called at a negedge; returns at the negedge after the result handshake.
    task automatic run_instr(input string tag, input logic [3:0] op, input logic [1:0] vsew,
                             input logic [NW_W-1:0] nw, input logic [VL-1:0] va,
                             input logic [VL-1:0] vb, input int bp, output logic [VL-1:0] vd_out);
        int n, exp_lat, lat, k;
        bit got;
        logic [VL-1:0] exp_vd, held;
        logic [31:0] exp_a, exp_b;

        n = (int'(nw) > NWORDS) ? NWORDS : int'(nw);
        exp_vd = '0;
        for (int i = 0; i < n; i++)
            exp_vd[32*i +: 32] = ref_word(op, vsew, va[32*i +: 32], vb[32*i +: 32]);
        exp_q.push_back(exp_vd);
        exp_lat = (n == 0) ? 1 : n + (is_arith(op) ? 2 : 1);

        k = 0;
        while (!instr_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_ready"}, VL'(instr_ready), VL'(1));

        instr_valid  = 1'b1;
        instr_op     = op;
        instr_vsew   = vsew;
        instr_nwords = nw;
        instr_vA     = va;
        instr_vB     = vb;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;

        got = 1'b0;
        lat = 1;
        for (lat = 1; lat <= 40; lat++) begin
            @(negedge clk);
            exp_a = (lat <= n) ? va[32*(lat-1) +: 32] : 32'd0;
            exp_b = (lat <= n) ? vb[32*(lat-1) +: 32] : 32'd0;
            check({tag, "_opA"}, VL'(alu_op_A), VL'(exp_a));
            check({tag, "_opB"}, VL'(alu_op_B), VL'(exp_b));
            if (res_valid) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_seen"}, VL'(got), VL'(1));
        check({tag, "_latency"}, VL'(lat), VL'(exp_lat));
        check({tag, "_vd"}, res_vd, exp_q.pop_front());
        check({tag, "_op_hold"}, VL'(alu_op_instr), VL'(op));
        check({tag, "_busy"}, VL'(instr_ready), VL'(0));
        vd_out = res_vd;

        held = res_vd;
        repeat (bp) begin
            @(negedge clk);
            check({tag, "_bp_valid"}, VL'(res_valid), VL'(1));
            check({tag, "_bp_stable"}, res_vd, held);
            check({tag, "_bp_ready"}, VL'(instr_ready), VL'(0));
        end

        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        check({tag, "_post_valid"}, VL'(res_valid), VL'(0));
        check({tag, "_post_ready"}, VL'(instr_ready), VL'(1));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [VL-1:0] vd, va, vb;
        logic [3:0] ops[5];
`ifdef V_ALU_SEQ_PERF_EN
        logic [31:0] p0;
`endif
        ops = '{VALU_VADD, VALU_VSUB, VALU_VAND, VALU_VOR, VALU_VXOR};

        nrst = 1'b0;
        instr_valid = 1'b0;
        instr_op = '0;
        instr_vsew = '0;
        instr_nwords = '0;
        instr_vA = '0;
        instr_vB = '0;
        res_ready = 1'b0;

        #12;
        check("rst_instr_ready", VL'(instr_ready), VL'(0));
        check("rst_res_valid", VL'(res_valid), VL'(0));
        check("rst_res_vd", res_vd, '0);
        check("rst_opA", VL'(alu_op_A), VL'(0));
        check("rst_opB", VL'(alu_op_B), VL'(0));
        check("rst_op_instr", VL'(alu_op_instr), VL'(0));
        check("rst_vsew", VL'(alu_vsew), VL'(0));
`ifdef V_ALU_SEQ_PERF_EN
        check("rst_perf", VL'(perf_busy_cycles), VL'(0));
`endif
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        // VADD 8-bit lanes, one word; upper words must come back zero.
        va = {$urandom, $urandom, $urandom, 32'h7F01FF10};
        vb = {$urandom, $urandom, $urandom, 32'h01010110};
        run_instr("vadd8", VALU_VADD, 2'd0, NW_W'(1), va, vb, 0, vd);
        check("vadd8_const", vd, {96'd0, 32'h80020020});

        run_instr("vand4", VALU_VAND, 2'd2, NW_W'(4), {4{32'hF0F0F0F0}}, {4{32'h3C3C3C3C}}, 1, vd);
        check("vand4_const", vd, {4{32'h30303030}});

        va = {64'hDEAD_BEEF_1234_5678, 32'hFFFFFFFF, 32'd1};
        vb = {64'h1111_2222_3333_4444, 32'd1, 32'd2};
        run_instr("vadd32", VALU_VADD, 2'd2, NW_W'(2), va, vb, 0, vd);
        check("vadd32_const", vd, {64'd0, 32'd0, 32'd3});

        run_instr("vor0", VALU_VOR, 2'd0, NW_W'(0), {4{$urandom}}, {4{$urandom}}, 3, vd);
        check("vor0_const", vd, '0);

        // Clamp: nwords above NWORDS behaves as NWORDS.
        run_instr("vxor_clamp", VALU_VXOR, 2'd1, NW_W'(7), {4{32'hA5A5_0F0F}}, {4{32'hFFFF_FFFF}}, 0, vd);
        check("vxor_clamp_const", vd, {4{32'h5A5A_F0F0}});

        // Reset in the middle of ISSUE word 1.
        instr_valid  = 1'b1;
        instr_op     = VALU_VADD;
        instr_vsew   = 2'd2;
        instr_nwords = NW_W'(4);
        instr_vA     = {32'd4, 32'd3, 32'h0000_0022, 32'h0000_0011};
        instr_vB     = '0;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        #2;
        check("mid_opA_word1", VL'(alu_op_A), VL'(32'h22));
        nrst = 1'b0;
        #1;
        check("mid_rst_valid", VL'(res_valid), VL'(0));
        check("mid_rst_opA", VL'(alu_op_A), VL'(0));
        check("mid_rst_ready", VL'(instr_ready), VL'(0));
        check("mid_rst_vd", res_vd, '0);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        check("post_rst_ready", VL'(instr_ready), VL'(1));
        check("post_rst_valid", VL'(res_valid), VL'(0));
        run_instr("post_rst_vadd", VALU_VADD, 2'd1, NW_W'(3),
                  {32'd0, 32'h0001_FFFF, 32'h8000_7FFF, 32'h0001_0002},
                  {32'd0, 32'h0001_0001, 32'h8000_0001, 32'h0002_0003}, 0, vd);
        check("post_rst_vadd_const", vd, {32'd0, 32'h0002_0000, 32'h0000_8000, 32'h0003_0005});

`ifdef V_ALU_SEQ_PERF_EN
        p0 = perf_busy_cycles;
        run_instr("perf_vadd", VALU_VADD, 2'd2, NW_W'(4), {4{$urandom}}, {4{$urandom}}, 2, vd);
        check("perf_busy_delta", VL'(perf_busy_cycles - p0), VL'(8));
`endif

        for (int t = 0; t < 40; t++) begin
            va = {$urandom, $urandom, $urandom, $urandom};
            vb = {$urandom, $urandom, $urandom, $urandom};
            run_instr("rand", ops[$urandom_range(0, 4)], 2'($urandom_range(0, 2)),
                      NW_W'($urandom_range(0, 7)), va, vb, int'($urandom_range(0, 3)), vd);
        end

        check("exp_q_empty", VL'(exp_q.size()), VL'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
